// File: rtl/exu_muldiv_pkg.sv
// Shared constants for the EXU multiply/divide unit.
// Holds default widths, M-extension decode constants, FSM state encodings,
// the captured-op control payload and small func3 decode helpers.
package exu_muldiv_pkg;

  localparam int unsigned MD_XLEN           = 32;
  localparam int unsigned MD_XREG_ADDRWIDTH = 5;

  // M-extension func3 op codes
  localparam logic [2:0] FUNC3_MUL    = 3'b000;
  localparam logic [2:0] FUNC3_MULH   = 3'b001;
  localparam logic [2:0] FUNC3_MULHSU = 3'b010;
  localparam logic [2:0] FUNC3_MULHU  = 3'b011;
  localparam logic [2:0] FUNC3_DIV    = 3'b100;
  localparam logic [2:0] FUNC3_DIVU   = 3'b101;
  localparam logic [2:0] FUNC3_REM    = 3'b110;
  localparam logic [2:0] FUNC3_REMU   = 3'b111;

  // Decode constants identifying an M-extension register-register op
  localparam logic [6:0] OPCODE_ALR      = 7'b0110011;
  localparam logic [6:0] FUNC7_0_000_001 = 7'b0000001;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [MD_XLEN-1:0] ZERO = '0;

  // Per-op control captured at acceptance
  typedef struct packed {
    logic [2:0] func3;
    logic       neg;    // negate the magnitude result at the end
  } md_ctl_t;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == FUNC3_MUL) || (f3 == FUNC3_MULH) || (f3 == FUNC3_MULHSU) ||
           (f3 == FUNC3_DIV) || (f3 == FUNC3_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM
  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == FUNC3_MUL) || (f3 == FUNC3_MULH) ||
           (f3 == FUNC3_DIV) || (f3 == FUNC3_REM);
  endfunction

endpackage

// File: rtl/exu_muldiv_iter_core.sv
// Iterative magnitude datapath: one radix-2 step per cycle.
// Multiply: shift-add, {hi,lo} ends as the 2*XLEN product of a*b.
// Divide: restoring shift-subtract, hi ends as remainder, lo as quotient.
// Ports: clk, rst_n; start loads a/b and the counter; step advances one
// iteration; div_mode selects subtract mode; last_c flags the final step;
// hi_nxt_c/lo_nxt_c are the register values after the current step.
module muldiv_iter_core
  import exu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last_c,
  output logic [XLEN-1:0] hi_nxt_c,
  output logic [XLEN-1:0] lo_nxt_c
);

  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  b_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    sum;
  logic [XLEN:0]    shl;
  logic [XLEN:0]    diff;

  assign last_c = (cnt == CNT_W'(1));

  // Single iteration step
  always_comb begin
    hi_nxt_c = hi;
    lo_nxt_c = lo;
    sum      = '0;
    shl      = '0;
    diff     = '0;
    if (div_q) begin
      // Partial remainder stays below b, so the shifted value fits XLEN+1
      // bits and a set diff MSB means the trial subtract borrowed.
      shl  = {hi, lo[XLEN-1]};
      diff = shl - {1'b0, b_q};
      if (!diff[XLEN]) begin
        hi_nxt_c = diff[XLEN-1:0];
        lo_nxt_c = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt_c = shl[XLEN-1:0];
        lo_nxt_c = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      hi_nxt_c = sum[XLEN:1];
      lo_nxt_c = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Datapath and iteration counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      hi    <= '0;
      lo    <= a;
      b_q   <= b;
      div_q <= div_mode;
      cnt   <= CNT_W'(XLEN);
    end else if (step) begin
      hi    <= hi_nxt_c;
      lo    <= lo_nxt_c;
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/exu_muldiv.sv
// EXU multi-cycle multiply/divide unit (RV32M/RV64M).
// Ports: clk, rst_n (async active-low), flush_in kills the in-flight op;
// in_valid/in_ready with func3_in, rs1_in, rs2_in, rd_addr_in issue an op;
// out_valid/out_ready with rd_out, rd_addr_out, rd_en_out return write-back.
// Build option MULDIV_FAST_MUL_EN: multiplies complete in a single cycle
// instead of the XLEN-cycle iterative path; divides are unaffected.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = MD_XLEN,
  parameter int unsigned XREG_ADDRWIDTH = MD_XREG_ADDRWIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                func3_in,
  input  logic [XLEN-1:0]           rs1_in,
  input  logic [XLEN-1:0]           rs2_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           rd_out,
  output logic [XREG_ADDRWIDTH-1:0] rd_addr_out,
  output logic                      rd_en_out
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  md_ctl_t                   ctl_q;
  md_ctl_t                   ctl_nxt;
  logic [XLEN-1:0]           rd_out_nxt;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_nxt;
  logic                      out_valid_nxt;
  logic                      in_ready_nxt;
  logic                      start;
  logic                      step;
  logic                      div_op;
  logic                      sa;
  logic                      sb;
  logic                      neg_sel;
  logic                      div_zero;
  logic                      div_ovf;
  logic [XLEN-1:0]           a_mag;
  logic [XLEN-1:0]           b_mag;
  logic                      core_last;
  logic [XLEN-1:0]           core_hi;
  logic [XLEN-1:0]           core_lo;
`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0]             fast_prod;
`endif

  // Apply result sign and select the architectural result from hi/lo
  function automatic logic [XLEN-1:0] finalize(input logic [2:0]      f3,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo,
                                               input logic            neg);
    logic [PW-1:0]   p;
    logic [XLEN-1:0] r;
    p = {hi, lo};
    r = '0;
    if (!f3[2]) begin
      if (neg) p = -p;
      r = (f3 == FUNC3_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    end else if (!f3[1]) begin
      r = neg ? -lo : lo;
    end else begin
      r = neg ? -hi : hi;
    end
    return r;
  endfunction

  // Operand decode: sign flags, magnitudes and special-case detection
  always_comb begin
    div_op   = func3_in[2];
    sa       = rs1_signed(func3_in) & rs1_in[XLEN-1];
    sb       = rs2_signed(func3_in) & rs2_in[XLEN-1];
    a_mag    = sa ? -rs1_in : rs1_in;
    b_mag    = sb ? -rs2_in : rs2_in;
    // Remainder takes the dividend sign; everything else the XOR
    neg_sel  = (div_op && func3_in[1]) ? sa : (sa ^ sb);
    div_zero = div_op && (rs2_in == '0);
    div_ovf  = div_op && !func3_in[0] &&
               (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_in == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = PW'(a_mag) * PW'(b_mag);
`endif

  assign step = (state == ST_CALC);

  muldiv_iter_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (step),
    .div_mode (div_op),
    .a        (a_mag),
    .b        (b_mag),
    .last_c   (core_last),
    .hi_nxt_c (core_hi),
    .lo_nxt_c (core_lo)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_nxt   = state;
    ctl_nxt     = ctl_q;
    rd_out_nxt  = rd_out;
    rd_addr_nxt = rd_addr_out;
    start       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready && !flush_in) begin
          ctl_nxt.func3 = func3_in;
          ctl_nxt.neg   = neg_sel;
          rd_addr_nxt   = rd_addr_in;
          if (div_zero) begin
            rd_out_nxt = func3_in[1] ? rs1_in : '1;
            state_nxt  = ST_DONE;
          end else if (div_ovf) begin
            rd_out_nxt = func3_in[1] ? '0 : rs1_in;
            state_nxt  = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!div_op) begin
            rd_out_nxt = finalize(func3_in, fast_prod[PW-1:XLEN],
                                  fast_prod[XLEN-1:0], neg_sel);
            state_nxt  = ST_DONE;
`endif
          end else begin
            start     = 1'b1;
            state_nxt = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush_in) begin
          state_nxt = ST_IDLE;
        end else if (core_last) begin
          // Final step's values are taken straight from the core
          rd_out_nxt = finalize(ctl_q.func3, core_hi, core_lo, ctl_q.neg);
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Flush and handshake both return to IDLE; flush drops the result
        if (flush_in || out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    out_valid_nxt = (state_nxt == ST_DONE);
    in_ready_nxt  = (state_nxt == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ctl_q       <= '0;
      rd_out      <= '0;
      rd_addr_out <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      state       <= state_nxt;
      ctl_q       <= ctl_nxt;
      rd_out      <= rd_out_nxt;
      rd_addr_out <= rd_addr_nxt;
      out_valid   <= out_valid_nxt;
      in_ready    <= in_ready_nxt;
    end
  end

  assign rd_en_out = out_valid;

endmodule

// File: tb/tb_exu_muldiv.sv
// Self-checking bench for exu_muldiv (XLEN=32): directed corner ops,
// randomized ops against an arithmetic reference model, backpressure,
// flush and mid-operation reset.
module tb_exu_muldiv;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush_in = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      func3_in = 3'd0;
  logic [XLEN-1:0] rs1_in = '0;
  logic [XLEN-1:0] rs2_in = '0;
  logic [AW-1:0]   rd_addr_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] rd_out;
  logic [AW-1:0]   rd_addr_out;
  logic            rd_en_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exu_muldiv #(.XLEN(XLEN), .XREG_ADDRWIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_in    (flush_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .func3_in    (func3_in),
    .rs1_in      (rs1_in),
    .rs2_in      (rs2_in),
    .rd_addr_in  (rd_addr_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rd_out      (rd_out),
    .rd_addr_out (rd_addr_out),
    .rd_en_out   (rd_en_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V M semantics via 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb;          r = p[31:0];  end
      3'd1: begin p = sa * sb;          r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub;          r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : 32'(ua % ub);
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    bit special;
    special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    if (special || (FAST && !f3[2])) return 1;
    return XLEN + 1;
  endfunction

  // Issue one op, wait for the result, hold it for 'hold' cycles, then retire
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0]   exp;
    logic [AW-1:0] rd;
    int            lat;
    exp = model(f3, a, b);
    rd  = AW'($urandom);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    func3_in   = f3;
    rs1_in     = a;
    rs2_in     = b;
    rd_addr_in = rd;
    @(negedge clk);
    in_valid   = 1'b0;
    rs1_in     = $urandom;
    rs2_in     = $urandom;
    func3_in   = 3'($urandom);
    rd_addr_in = AW'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_latency(f3, a, b)));
    check({tag, "_rd"}, 64'(rd_out), 64'(exp));
    check({tag, "_rd_addr"}, 64'(rd_addr_out), 64'(rd));
    check({tag, "_rd_en"}, 64'(rd_en_out), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_rd"}, 64'(rd_out), 64'(exp));
      check({tag, "_hold_addr"}, 64'(rd_addr_out), 64'(rd));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retire_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_retire_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_rd_out", 64'(rd_out), 64'd0);
    check("reset_rd_addr", 64'(rd_addr_out), 64'd0);
    check("reset_rd_en", 64'(rd_en_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    run_op("mulh_min_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 0);
    run_op("mulhu_ff_ff",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    run_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF,  32'd2,         0);
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         0);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         0);
    run_op("divu_ff_2",    3'd5, 32'hFFFF_FFFF,  32'd2,         0);
    run_op("div_5_0",      3'd4, 32'd5,          32'd0,         0);
    run_op("remu_5_0",     3'd7, 32'd5,          32'd0,         0);
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op("divu_min_m1",  3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op("backpressure", 3'd6, 32'd1000,       32'hFFFF_FFF9, 5);
    check("sanity_mul_model", 64'(model(3'd0, 32'd7, 32'hFFFF_FFFD)), 64'hFFFF_FFEB);

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom), pick_operand(), pick_operand(),
             int'($urandom_range(0, 2)));
    end

    // Flush at cycle 10 of a DIV
    @(negedge clk);
    in_valid = 1'b1; func3_in = 3'd4; rs1_in = 32'd100; rs2_in = 32'd7; rd_addr_in = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_calc_busy", 64'(in_ready), 64'd0);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    check("flush_calc_valid", 64'(out_valid), 64'd0);
    check("flush_calc_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_calc_no_result", 64'(seen), 64'd0);

    // Flush in DONE wins over a simultaneous out_ready
    @(negedge clk);
    in_valid = 1'b1; func3_in = 3'd5; rs1_in = 32'd9; rs2_in = 32'd0; rd_addr_in = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_done_valid_pre", 64'(out_valid), 64'd1);
    flush_in = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush_in = 1'b0; out_ready = 1'b0;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    check("flush_done_in_ready", 64'(in_ready), 64'd1);

    // Flush in IDLE blocks acceptance (div-by-zero would show at once)
    @(negedge clk);
    in_valid = 1'b1; flush_in = 1'b1; func3_in = 3'd4; rs1_in = 32'd1; rs2_in = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; flush_in = 1'b0;
    check("flush_idle_valid", 64'(out_valid), 64'd0);
    check("flush_idle_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-CALC
    run_op("pre_reset", 3'd5, 32'd12345, 32'd10, 0);
    @(negedge clk);
    in_valid = 1'b1; func3_in = 3'd4; rs1_in = 32'd77; rs2_in = 32'd5; rd_addr_in = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_rd_out", 64'(rd_out), 64'd0);
    check("rst_mid_rd_addr", 64'(rd_addr_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_mid_no_result", 64'(seen), 64'd0);
    run_op("post_reset", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
